display_scan_ctrl: RTL and testbench

Time-multiplexes NUM_DIGITS 4-bit digit codes through the single shared 7-segment decoder (inputs qd,qc,qb,qa) and drives one-hot digit enables. Provides double-buffered digit/enable loading committed only at frame boundaries, plus a guard blank interval between digits to prevent ghosting. Sits between the system's result registers and the decoder/display pins.

---
 rtl/display_scan_ctrl.sv | 145 ++++++++++++++
 tb/tb_display_scan_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan controller with frame-boundary double buffering and guard blanking.
// Optional leading-zero blanking is enabled by defining DISPLAY_SCAN_LZB_EN.
module display_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   data_in,
    input  logic [NUM_DIGITS-1:0]     en_in,
    output logic                      qd,
    output logic                      qc,
    output logic                      qb,
    output logic                      qa,
    output logic [NUM_DIGITS-1:0]     digit_en,
    output logic                      frame_done
);

    localparam int CNT_MAX    = (PRESCALE > BLANK_CYCLES) ?
                                ((PRESCALE > 2) ? PRESCALE : 2) :
                                ((BLANK_CYCLES > 2) ? BLANK_CYCLES : 2);
    localparam int CW         = $clog2(CNT_MAX);
    localparam int IW         = $clog2(NUM_DIGITS);
    localparam int SHOW_LAST  = PRESCALE - 1;
    localparam int BLANK_LAST = (BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1;

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;

    logic [0:0]              state, state_nx;
    logic [IW-1:0]           idx, idx_nx;
    logic [CW-1:0]           cnt, cnt_nx;
    logic [4*NUM_DIGITS-1:0] shadow_data, active_data, active_data_nx;
    logic [NUM_DIGITS-1:0]   shadow_en, active_en, active_en_nx;
    logic                    pending, pending_nx;
    logic                    blank_last, show_last, commit_cycle;
    logic [3:0]              codes_nx [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   lit_nx;
    logic [NUM_DIGITS-1:0]   digit_en_nx;

    assign blank_last   = (state == ST_BLANK) &&
                          ((BLANK_CYCLES == 0) || (cnt == CW'(BLANK_LAST)));
    assign show_last    = (state == ST_SHOW) && (cnt == CW'(SHOW_LAST));
    assign commit_cycle = show_last && (idx == IW'(NUM_DIGITS - 1));

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        cnt_nx   = cnt + CW'(1);
        if (blank_last) begin
            state_nx = ST_SHOW;
            cnt_nx   = '0;
        end else if (show_last) begin
            idx_nx   = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
            state_nx = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
            cnt_nx   = '0;
        end
    end

    // A load coinciding with the commit cycle bypasses the shadow buffer.
    always_comb begin
        active_data_nx = active_data;
        active_en_nx   = active_en;
        pending_nx     = pending;
        if (commit_cycle) begin
            pending_nx = 1'b0;
            if (load) begin
                active_data_nx = data_in;
                active_en_nx   = en_in;
            end else if (pending) begin
                active_data_nx = shadow_data;
                active_en_nx   = shadow_en;
            end
        end else if (load) begin
            pending_nx = 1'b1;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            codes_nx[i] = active_data_nx[4*i +: 4];
        end
    end

`ifdef DISPLAY_SCAN_LZB_EN
    logic [NUM_DIGITS-1:0] lz_nx;

    always_comb begin
        lz_nx = '0;
        lz_nx[NUM_DIGITS-1] = (codes_nx[NUM_DIGITS-1] == 4'h0);
        for (int unsigned i = NUM_DIGITS - 2; i >= 1; i--) begin
            lz_nx[i] = (codes_nx[i] == 4'h0) && lz_nx[i+1];
        end
        lz_nx[0] = 1'b0;
    end

    assign lit_nx = active_en_nx & ~lz_nx;
`else
    assign lit_nx = active_en_nx;
`endif

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_comb begin
        digit_en_nx = '0;
        if (state_nx == ST_SHOW) begin
            digit_en_nx[idx_nx] = lit_nx[idx_nx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_BLANK;
            idx         <= '0;
            cnt         <= '0;
            shadow_data <= '0;
            shadow_en   <= '0;
            active_data <= '0;
            active_en   <= '0;
            pending     <= 1'b0;
            qd          <= 1'b0;
            qc          <= 1'b0;
            qb          <= 1'b0;
            qa          <= 1'b0;
            digit_en    <= '0;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_nx;
            idx         <= idx_nx;
            cnt         <= cnt_nx;
            active_data <= active_data_nx;
            active_en   <= active_en_nx;
            pending     <= pending_nx;
            if (load) begin
                shadow_data <= data_in;
                shadow_en   <= en_in;
            end
            {qd, qc, qb, qa} <= codes_nx[idx_nx];
            digit_en    <= digit_en_nx;
            frame_done  <= commit_cycle;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with N=4, PRESCALE=4, BLANK_CYCLES=1 (20-cycle frames).
module tb_display_scan_ctrl;

    localparam int N  = 4;
    localparam int P  = 4;
    localparam int B  = 1;
    localparam int SL = P + B;
    localparam int FL = N * SL;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           load;
    logic [4*N-1:0] data_in;
    logic [N-1:0]   en_in;
    logic           qd, qc, qb, qa;
    logic [N-1:0]   digit_en;
    logic           frame_done;

    int vectors = 0;
    int miscompares = 0;

    display_scan_ctrl #(
        .NUM_DIGITS   (N),
        .PRESCALE     (P),
        .BLANK_CYCLES (B)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .data_in    (data_in),
        .en_in      (en_in),
        .qd         (qd),
        .qc         (qc),
        .qb         (qb),
        .qa         (qa),
        .digit_en   (digit_en),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Counts negedges until frame_done is seen, bounded.
    task automatic wait_fd(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 100);
    endtask

    // Entered at the negedge of frame cycle 0; leaves at cycle 0 of the following frame.
    task automatic check_frame(input string tag, input logic [4*N-1:0] data, input logic [N-1:0] lit);
        for (int c = 0; c < FL; c++) begin
            int d, ph;
            logic [3:0] code;
            logic [N-1:0] en_exp;
            if (c > 0) @(negedge clk);
            d      = c / SL;
            ph     = c % SL;
            code   = data[4*d +: 4];
            en_exp = (ph >= B && lit[d]) ? N'(1 << d) : '0;
            check($sformatf("%s_fd_c%0d", tag, c), 32'(frame_done), 32'(c == 0));
            check($sformatf("%s_q_c%0d", tag, c), 32'({qd, qc, qb, qa}), 32'(code));
            check($sformatf("%s_en_c%0d", tag, c), 32'(digit_en), 32'(en_exp));
        end
        @(negedge clk);
        check($sformatf("%s_next_fd", tag), 32'(frame_done), 32'd1);
    endtask

    task automatic pulse_load(input int at, input logic [4*N-1:0] d, input logic [N-1:0] e);
        repeat (at) @(posedge clk);
        #1;
        load    = 1'b1;
        data_in = d;
        en_in   = e;
        @(posedge clk);
        #1;
        load    = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_q"}, 32'({qd, qc, qb, qa}), 32'd0);
        check({tag, "_en"}, 32'(digit_en), 32'd0);
        check({tag, "_fd"}, 32'(frame_done), 32'd0);
    endtask

    initial begin
        int n;
        logic [N-1:0] lzb_lit;
        rst_n   = 1'b0;
        load    = 1'b0;
        data_in = '0;
        en_in   = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_fd(n);
        check("first_frame_len", 32'(n), 32'(FL + 1));
        check_frame("idle", '0, '0);

        fork
            check_frame("hold", '0, '0);
            pulse_load(7, 16'h4321, 4'hF);
        join
        check_frame("f4321", 16'h4321, 4'hF);

        fork
            check_frame("f4321b", 16'h4321, 4'hF);
            pulse_load(9, 16'h4321, 4'b1011);
        join
        check_frame("mask", 16'h4321, 4'b1011);

        // Earlier load superseded by one on the commit cycle itself.
        fork
            check_frame("pre9876", 16'h4321, 4'b1011);
            begin
                pulse_load(3, 16'h5555, 4'h3);
                pulse_load(15, 16'h9876, 4'hF);
            end
        join
        check_frame("f9876", 16'h9876, 4'hF);
        check_frame("f9876b", 16'h9876, 4'hF);

        repeat (12) @(posedge clk);
        #1;
        check("pre_rst_en", 32'(digit_en), 32'(4'b0100));
        check("pre_rst_q", 32'({qd, qc, qb, qa}), 32'h8);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_fd(n);
        check("rst_frame_len", 32'(n), 32'(FL + 1));

`ifdef DISPLAY_SCAN_LZB_EN
        lzb_lit = 4'b0011;
`else
        lzb_lit = 4'b1111;
`endif
        fork
            check_frame("post_rst", '0, '0);
            pulse_load(5, 16'h0050, 4'hF);
        join
        check_frame("lzb", 16'h0050, lzb_lit);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
